// File: rtl/dmem_pkg.sv
// Shared types and constants for the MEM-stage data-memory responder.
package dmem_pkg;

   localparam int unsigned DMEM_DATA_W     = 32;
   localparam int unsigned DMEM_WORD_BYTES = 4;
   localparam int unsigned DMEM_CNT_W      = 4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } dmem_state_t;

   typedef enum logic {
      OP_READ  = 1'b0,
      OP_WRITE = 1'b1
   } dmem_op_t;

endpackage : dmem_pkg

// File: rtl/dmem_array.sv
// Single-port synchronous word RAM; read data is held until the next read.
module dmem_array
   import dmem_pkg::*;
#(
   parameter int unsigned DEPTH_WORDS = 256,
   localparam int unsigned IDX_W      = $clog2(DEPTH_WORDS)
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   en,
   input  logic                   we,
   input  logic [IDX_W-1:0]       idx,
   input  logic [DMEM_DATA_W-1:0] wdata,
   output logic [DMEM_DATA_W-1:0] rdata
);

   logic [DMEM_DATA_W-1:0] mem [DEPTH_WORDS];

   // Storage is intentionally not reset.
   always_ff @(posedge clk) begin
      if (en && we) begin
         mem[idx] <= wdata;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rdata <= '0;
      end else if (en && !we) begin
         rdata <= mem[idx];
      end
   end

endmodule : dmem_array

// File: rtl/dmem_responder.sv
// Fixed-latency data-memory responder: stalls the pipeline for LATENCY+1
// cycles per access, then pulses ack with the read data registered.
module dmem_responder
   import dmem_pkg::*;
#(
   parameter int unsigned DEPTH_WORDS = 256,
   parameter int unsigned LATENCY     = 4
) (
   input  logic                   clk_i,
   input  logic                   rst_i,
   input  logic [31:0]            addr_i,
   input  logic [DMEM_DATA_W-1:0] w_data_i,
   input  logic                   MemRead_i,
   input  logic                   MemWrite_i,
   output logic [DMEM_DATA_W-1:0] r_data_o,
   output logic                   stall_o,
   output logic                   ack_o
);

   localparam int unsigned IDX_W   = $clog2(DEPTH_WORDS);
   localparam int unsigned IDX_LSB = $clog2(DMEM_WORD_BYTES);

   dmem_state_t            state;
   dmem_op_t               op;
   logic [DMEM_CNT_W-1:0]  count;
   logic [IDX_W-1:0]       idx_q;
   logic [DMEM_DATA_W-1:0] wdata_q;

   logic req;
   logic mem_en;
   logic mem_we;
   logic unused_addr_bits;

   assign req = MemRead_i | MemWrite_i;

   // Byte offset and bits above the index are dropped, so addresses wrap.
   assign unused_addr_bits = ^{addr_i[31:IDX_W+IDX_LSB], addr_i[IDX_LSB-1:0]};

   // The access itself happens on the edge that leaves BUSY.
   assign mem_en = (state == BUSY) && (count == '0);
   assign mem_we = mem_en && (op == OP_WRITE);

   // Stall must follow the request in IDLE within the same cycle.
   assign stall_o = rst_i && ((state == BUSY) || ((state == IDLE) && req));

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state   <= IDLE;
         op      <= OP_READ;
         count   <= '0;
         idx_q   <= '0;
         wdata_q <= '0;
         ack_o   <= 1'b0;
      end else begin
         ack_o <= 1'b0;
         case (state)
            IDLE: begin
               if (req) begin
                  op      <= MemWrite_i ? OP_WRITE : OP_READ;
                  idx_q   <= addr_i[IDX_W+IDX_LSB-1:IDX_LSB];
                  wdata_q <= w_data_i;
                  count   <= DMEM_CNT_W'(LATENCY - 1);
                  state   <= BUSY;
               end
            end
            BUSY: begin
               if (count == '0) begin
                  state <= DONE;
                  ack_o <= 1'b1;
               end else begin
                  count <= count - DMEM_CNT_W'(1);
               end
            end
            // The completed request is still presented here; ignore it.
            DONE:    state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

   dmem_array #(
      .DEPTH_WORDS (DEPTH_WORDS)
   ) u_array (
      .clk   (clk_i),
      .rst_n (rst_i),
      .en    (mem_en),
      .we    (mem_we),
      .idx   (idx_q),
      .wdata (wdata_q),
      .rdata (r_data_o)
   );

endmodule : dmem_responder

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder with LATENCY=4, DEPTH_WORDS=256.
module tb_dmem_responder;

   localparam int unsigned LAT   = 4;
   localparam int unsigned DEPTH = 256;

   logic        clk_i = 1'b0;
   logic        rst_i;
   logic [31:0] addr_i;
   logic [31:0] w_data_i;
   logic        MemRead_i;
   logic        MemWrite_i;
   logic [31:0] r_data_o;
   logic        stall_o;
   logic        ack_o;

   int checks   = 0;
   int failures = 0;

   always #5 clk_i = ~clk_i;

   dmem_responder #(
      .DEPTH_WORDS (DEPTH),
      .LATENCY     (LAT)
   ) dut (
      .clk_i      (clk_i),
      .rst_i      (rst_i),
      .addr_i     (addr_i),
      .w_data_i   (w_data_i),
      .MemRead_i  (MemRead_i),
      .MemWrite_i (MemWrite_i),
      .r_data_o   (r_data_o),
      .stall_o    (stall_o),
      .ack_o      (ack_o)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Full access starting just after a rising edge; returns r_data_o at ack.
   task automatic access(input string tag, input logic rd, input logic wr,
                         input logic [31:0] addr, input logic [31:0] data,
                         output logic [31:0] rdat);
      int stalls;
      bit acked;
      stalls = 0;
      acked  = 0;
      rdat   = 'x;
      MemRead_i  = rd;
      MemWrite_i = wr;
      addr_i     = addr;
      w_data_i   = data;
      for (int c = 0; c < 20 && !acked; c++) begin
         @(negedge clk_i);
         if (ack_o === 1'b1) begin
            acked = 1;
            rdat  = r_data_o;
            check({tag, "_ack_cycle"}, 32'(c), 32'(LAT + 1));
            check({tag, "_stall_at_ack"}, 32'(stall_o), 32'd0);
         end else if (stall_o === 1'b1) begin
            stalls++;
         end
         @(posedge clk_i);
         #1;
      end
      MemRead_i  = 1'b0;
      MemWrite_i = 1'b0;
      check({tag, "_acked"}, 32'(acked), 32'd1);
      check({tag, "_stall_cycles"}, 32'(stalls), 32'(LAT + 1));
      @(negedge clk_i);
      check({tag, "_ack_pulse"}, 32'(ack_o), 32'd0);
      check({tag, "_idle_stall"}, 32'(stall_o), 32'd0);
      @(posedge clk_i);
      #1;
   endtask

   initial begin
      logic [31:0] rd;
      int ack1, ack2, nacks;

      // Reset with a request already present: stall must stay low.
      rst_i      = 1'b0;
      MemRead_i  = 1'b1;
      MemWrite_i = 1'b0;
      addr_i     = 32'h10;
      w_data_i   = 32'h0;
      @(negedge clk_i);
      check("rst_stall", 32'(stall_o), 32'd0);
      check("rst_ack", 32'(ack_o), 32'd0);
      check("rst_rdata", r_data_o, 32'd0);
      MemRead_i = 1'b0;
      @(posedge clk_i);
      #1;
      rst_i = 1'b1;

      for (int i = 0; i < 4; i++) begin
         @(negedge clk_i);
         check("idle_stall", 32'(stall_o), 32'd0);
         check("idle_ack", 32'(ack_o), 32'd0);
         check("idle_rdata", r_data_o, 32'd0);
      end
      @(posedge clk_i);
      #1;

      access("wr10", 1'b0, 1'b1, 32'h10, 32'hDEADBEEF, rd);
      check("wr10_rdata_held", rd, 32'd0);
      access("rd10", 1'b1, 1'b0, 32'h10, 32'h0, rd);
      check("rd10_data", rd, 32'hDEADBEEF);
      access("rd13", 1'b1, 1'b0, 32'h13, 32'h0, rd);
      check("rd13_data", rd, 32'hDEADBEEF);
      access("rdwrap", 1'b1, 1'b0, 32'h10 + DEPTH * 4, 32'h0, rd);
      check("rdwrap_data", rd, 32'hDEADBEEF);
      access("rdhigh", 1'b1, 1'b0, 32'h8000_0010, 32'h0, rd);
      check("rdhigh_data", rd, 32'hDEADBEEF);

      // Both strobes high is a write.
      access("both20", 1'b1, 1'b1, 32'h20, 32'h5, rd);
      check("both20_rdata_held", rd, 32'hDEADBEEF);
      access("rd20", 1'b1, 1'b0, 32'h20, 32'h0, rd);
      check("rd20_data", rd, 32'h5);

      // Inputs changed and request dropped during BUSY.
      access("wr44", 1'b0, 1'b1, 32'h44, 32'h1234, rd);
      MemWrite_i = 1'b1;
      addr_i     = 32'h40;
      w_data_i   = 32'hA5A5;
      @(posedge clk_i);
      #1;
      MemWrite_i = 1'b0;
      addr_i     = 32'h44;
      w_data_i   = 32'hFFFF_FFFF;
      ack1 = -1;
      for (int c = 1; c < 20 && ack1 < 0; c++) begin
         @(negedge clk_i);
         if (ack_o === 1'b1) ack1 = c;
         @(posedge clk_i);
         #1;
      end
      check("busychg_ack_cycle", 32'(ack1), 32'(LAT + 1));
      access("rd40", 1'b1, 1'b0, 32'h40, 32'h0, rd);
      check("rd40_data", rd, 32'hA5A5);
      access("rd44", 1'b1, 1'b0, 32'h44, 32'h0, rd);
      check("rd44_data", rd, 32'h1234);

      // Request held continuously: acks spaced LATENCY+2 apart.
      MemRead_i = 1'b1;
      addr_i    = 32'h20;
      ack1  = -1;
      ack2  = -1;
      nacks = 0;
      for (int c = 0; c < 30 && nacks < 2; c++) begin
         @(negedge clk_i);
         if (ack_o === 1'b1) begin
            if (nacks == 0) ack1 = c;
            else ack2 = c;
            nacks++;
            check("b2b_rdata", r_data_o, 32'h5);
         end
         @(posedge clk_i);
         #1;
      end
      MemRead_i = 1'b0;
      check("b2b_first_ack", 32'(ack1), 32'(LAT + 1));
      check("b2b_second_ack", 32'(ack2), 32'(2 * (LAT + 2) - 1));
      @(negedge clk_i);
      check("b2b_idle_stall", 32'(stall_o), 32'd0);
      @(posedge clk_i);
      #1;

      // Reset mid-BUSY aborts the write.
      access("wr30", 1'b0, 1'b1, 32'h30, 32'h1, rd);
      MemWrite_i = 1'b1;
      addr_i     = 32'h30;
      w_data_i   = 32'h99;
      @(posedge clk_i);
      #1;
      @(posedge clk_i);
      #1;
      rst_i = 1'b0;
      @(negedge clk_i);
      check("midrst_stall", 32'(stall_o), 32'd0);
      check("midrst_ack", 32'(ack_o), 32'd0);
      check("midrst_rdata", r_data_o, 32'd0);
      MemWrite_i = 1'b0;
      @(posedge clk_i);
      #1;
      rst_i = 1'b1;
      nacks = 0;
      for (int c = 0; c < 8; c++) begin
         @(negedge clk_i);
         if (ack_o === 1'b1 || stall_o === 1'b1) nacks++;
         @(posedge clk_i);
         #1;
      end
      check("postrst_quiet", 32'(nacks), 32'd0);
      access("rd30", 1'b1, 1'b0, 32'h30, 32'h0, rd);
      check("rd30_data", rd, 32'h1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule : tb_dmem_responder

// File: doc/dmem_responder.md
# dmem_responder

Multi-cycle data-memory responder for the MEM stage of the pipelined CPU. It accepts the pipeline's MemRead/MemWrite requests, holds the pipeline with a stall signal while a fixed-latency access completes, then returns read data with a one-cycle acknowledge. It replaces the zero-latency data memory and is the slave end of the CPU's data-memory request interface.

## Interface

Parameters:
- `DEPTH_WORDS`, default 256: number of 32-bit words; power of two.
- `LATENCY`, default 4: BUSY cycles per access; legal range 1..15.

Ports:
- `clk_i` in 1: clock, rising edge.
- `rst_i` in 1: reset, asynchronous, active-low.
- `addr_i` in 32: byte address from EX/MEM ALU result.
- `w_data_i` in 32: store data.
- `MemRead_i` in 1: load request.
- `MemWrite_i` in 1: store request.
- `r_data_o` out 32: load data, registered.
- `stall_o` out 1: hold PC, IF/ID, ID/EX, EX/MEM and MEM/WB this cycle.
- `ack_o` out 1: one-cycle pulse on access completion.

## Operation

- FSM states: IDLE, BUSY, DONE.
- A request is `MemRead_i | MemWrite_i`. If both are set, the access is a write, with write taking priority.
- IDLE:
  - `stall_o = req`, combinational from inputs.
  - On a clock edge with req: latch op, word index `addr_i[log2(DEPTH_WORDS)+1:2]`, and `w_data_i`. Set count to `LATENCY-1` and go to BUSY.
  - Without req: stay in IDLE.
- BUSY:
  - `stall_o = 1`.
  - Inputs are ignored; only the latched request is used.
  - Count decrements each edge.
  - On the edge where count == 0, perform the access and go to DONE:
    - Write: array[idx] ← wdata.
    - Read: `r_data_o` ← array[idx].
- DONE:
  - `stall_o = 0`, `ack_o = 1`.
  - Inputs are ignored, because the pipeline still presents the completed request during this cycle.
  - Next edge: go to IDLE.
- Address handling:
  - `addr_i[1:0]` is ignored (word access only).
  - Address bits above the index are ignored, so addresses wrap modulo `DEPTH_WORDS*4`.
- `r_data_o` holds the last read value through writes and idle periods.
- Array contents are not reset and are uninitialised in simulation unless preloaded.

## Timing

- Reset values: state IDLE, `r_data_o` = 0, `ack_o` = 0, count = 0. `stall_o` = 0 while reset is asserted, regardless of requests.
- Request first seen in cycle 0 (IDLE):
  - `stall_o` is high in cycles 0..LATENCY.
  - `ack_o` is high in cycle LATENCY+1, with `stall_o` low and `r_data_o` valid.
  - The pipeline advances at the end of cycle LATENCY+1.
- Back-to-back memory instructions:
  - The next request is seen in IDLE at cycle LATENCY+2.
  - Minimum spacing between acks is LATENCY+2 cycles.
- Reset asserted mid-BUSY: the access is aborted, the array is unmodified, and the FSM returns to IDLE immediately.
- Reset asserted in DONE: the write already committed remains in the array; outputs return to their reset values.
- Request deasserted during BUSY: the access completes anyway and the ack is still issued.

## Structure

- Shared package `dmem_pkg`:
  - `dmem_state_t` enum (IDLE, BUSY, DONE).
  - `dmem_op_t` (OP_READ, OP_WRITE).
  - Constant `DMEM_WORD_BYTES = 4`.
- Sub-module `dmem_array`:
  - Single-port synchronous RAM, `DEPTH_WORDS` × 32.
  - Ports: write enable, index, wdata, registered rdata.
  - Read data is captured into `r_data_o` on the BUSY→DONE edge.
- Top level: FSM, counter (4 bits), request latches, output logic.

## Test plan

- Reset, then idle with no requests -> `stall_o`=0, `ack_o`=0, `r_data_o`=0 indefinitely.
- Write 0xDEADBEEF to 0x10, LATENCY=4 -> `stall_o` high 5 cycles, `ack_o` in the 6th. Then read 0x10 -> `r_data_o`=0xDEADBEEF with `ack_o`, and `r_data_o` unchanged during the preceding write.
- Read of 0x13 and of 0x10+DEPTH_WORDS*4 -> both return the word at 0x10 (low-bit drop and wrap).
- `MemRead_i` and `MemWrite_i` both high, addr 0x20, data 0x5 -> treated as a write; a later read of 0x20 returns 0x5 and `r_data_o` is unchanged at that write's ack.
- Change `addr_i`/`w_data_i` and drop the request during BUSY -> the originally latched address/data are used and the ack still fires at cycle LATENCY+1.
- Assert `rst_i` low during BUSY of a write to 0x30 that holds 0x1 -> IDLE, `stall_o`=0, no ack, and a subsequent read of 0x30 returns 0x1.
